// File: rtl/serial_paralelo_rx_pkg.sv
// Shared definitions for the PCIe lane serial-to-parallel receiver:
// the COM symbol, the FSM state type and the counter widths.
package sp_rx_pkg;

  // K28.5 COM symbol used for byte alignment and idle fill
  localparam logic [7:0] COM_SYM = 8'hBC;

  // Width of the bit-phase counter (8 bits per byte)
  localparam int PHASE_W = 3;

  // Width of the consecutive-COM counter (COM_COUNT up to 15)
  localparam int COM_CNT_W = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_t;

  // True when a byte is the COM symbol
  function automatic logic is_com_sym(input logic [7:0] b);
    return (b == COM_SYM);
  endfunction

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Lane-side bundle of the deserializer: the serial bit going in and the
// parallel payload, its strobe and the lane-active flag coming out.
// master: the side feeding serial bits and consuming the parallel words.
// slave:  the deserializer itself.
interface serial_paralelo_rx_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );

endinterface

// File: rtl/serial_paralelo_rx_comma_det.sv
// COM symbol detector. Purely combinational so it can be shared with the
// serializer-side checker, which looks at the same byte window.
module sp_rx_comma_det
  import sp_rx_pkg::*;
(
  input  logic [7:0] nsr,
  output logic       is_com
);

  assign is_com = is_com_sym(nsr);

endmodule

// File: rtl/serial_paralelo_rx.sv
// Receive-side serial-to-parallel deserializer for one PCIe PHY lane.
// Shifts in one bit per clk_32f edge (MSB first), hunts for the COM symbol
// at any bit offset, confirms alignment with COM_COUNT consecutive aligned
// COMs and then delivers every non-COM byte with a one-cycle valid strobe.
// Idle COMs are swallowed so downstream logic only sees payload.
//
// Optional feature: define SP_RX_LOSS_DETECT_EN to drop back to SEARCH when
// a COM shows up off the byte boundary while ACTIVE. Without it, only reset
// leaves ACTIVE.
module serial_paralelo_rx
  import sp_rx_pkg::*;
#(
  parameter int COM_COUNT = 4   // consecutive aligned COMs to lock, 1..15
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  serial_paralelo_rx_if.slave  bus
);

  localparam logic [COM_CNT_W-1:0] COM_TARGET = COM_CNT_W'(COM_COUNT);

  rx_state_t              state, state_n;
  logic [7:0]             sr;
  logic [7:0]             nsr;
  logic [PHASE_W-1:0]     cnt, cnt_n;
  logic [COM_CNT_W-1:0]   com_cnt, com_cnt_n, com_cnt_inc;
  logic                   is_com;
  logic                   boundary;

  // Output register stage: payload byte and its strobe travel together
  logic [7:0]             data_p1, data_n;
  logic                   vld_p1, vld_n;

  // Stage 0: byte window formed from the shift register plus the new bit
  assign nsr         = {sr[6:0], bus.data_in};
  assign boundary    = (cnt == '1);
  assign com_cnt_inc = com_cnt + COM_CNT_W'(1);

  sp_rx_comma_det u_comma_det (
    .nsr    (nsr),
    .is_com (is_com)
  );

  // Next-state, counter and output decisions for the alignment FSM
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + PHASE_W'(1);
    com_cnt_n = com_cnt;
    data_n    = data_p1;
    vld_n     = 1'b0;

    unique case (state)
      SEARCH: begin
        // Bit-by-bit hunt: a hit resets the phase so this COM ends a byte
        if (is_com) begin
          cnt_n     = '0;
          com_cnt_n = COM_CNT_W'(1);
          state_n   = (COM_COUNT == 1) ? ACTIVE : ALIGN;
        end
      end

      ALIGN: begin
        // Only whole bytes count; any non-COM byte breaks the run
        if (boundary) begin
          if (is_com) begin
            com_cnt_n = com_cnt_inc;
            if (com_cnt_inc == COM_TARGET) begin
              state_n = ACTIVE;
            end
          end else begin
            com_cnt_n = '0;
            state_n   = SEARCH;
          end
        end
      end

      ACTIVE: begin
        // Payload bytes are delivered; idle COMs just keep the strobe low
        if (boundary) begin
          if (!is_com) begin
            data_n = nsr;
            vld_n  = 1'b1;
          end
        end
`ifdef SP_RX_LOSS_DETECT_EN
        // A COM off the boundary means the lane slipped: realign
        else if (is_com) begin
          state_n   = SEARCH;
          com_cnt_n = '0;
        end
`endif
      end

      default: begin
        state_n   = SEARCH;
        com_cnt_n = '0;
      end
    endcase
  end

  // State, shift register, counters and output stage registers
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state   <= SEARCH;
      sr      <= '0;
      cnt     <= '0;
      com_cnt <= '0;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= nsr;
      cnt     <= cnt_n;
      com_cnt <= com_cnt_n;
      data_p1 <= data_n;
      vld_p1  <= vld_n;
    end
  end

  // Stage 1: registered outputs; active follows the registered state
  assign bus.data_out  = data_p1;
  assign bus.valid_out = vld_p1;
  assign bus.active    = (state == ACTIVE);

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Testbench for serial_paralelo_rx. A byte-level reference model scans the
// whole bit stream of an episode for the first COM, confirms the run of
// aligned COMs, then walks the stream in 8-bit steps to predict strobes,
// held data and the active flag after every clock edge.
module tb_serial_paralelo_rx;
  import sp_rx_pkg::*;

  localparam int COM_COUNT = 4;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  serial_paralelo_rx_if bus();

  serial_paralelo_rx #(.COM_COUNT(COM_COUNT)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  int tests = 0;
  int fails = 0;

  logic       stim[$];
  logic       exp_v[$];
  logic [7:0] exp_d[$];
  logic       exp_a[$];
  logic       obs_v[$];
  logic [7:0] obs_d[$];
  logic       obs_a[$];

  typedef struct {
    int          nlead;
    int          nbytes;
    logic [63:0] bytes;
    int          exp_cnt;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
    logic        exp_act;
    int          exp_rise;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) stim.push_back(b[k]);
  endtask

  // Last 8 stream bits ending at index i; bits before the episode are zero
  function automatic logic [7:0] win(input int i);
    logic [7:0] w;
    w = '0;
    for (int k = i - 7; k <= i; k++) w = {w[6:0], (k >= 0) ? stim[k] : 1'b0};
    return w;
  endfunction

  task automatic model_run();
    int n, i, j, k, m;
    bit ok, lost;
    logic [7:0] d;
    logic [7:0] cap[$];
    n = stim.size();
    exp_v = {}; exp_d = {}; exp_a = {};
    for (int x = 0; x < n; x++) begin
      exp_v.push_back(1'b0);
      exp_a.push_back(1'b0);
      cap.push_back(8'h00);
    end
    i = 0;
    m = 0;
    while (i < n) begin
      while (i < n && win(i) != COM_SYM) i++;
      if (i >= n) break;
      k = 1; j = i; ok = 1'b1;
      while (k < COM_COUNT) begin
        j += 8;
        if (j >= n) begin ok = 1'b0; break; end
        if (win(j) == COM_SYM) k++;
        else begin ok = 1'b0; break; end
      end
      if (!ok) begin i = j + 1; continue; end
      exp_a[j] = 1'b1;
      lost = 1'b0;
      for (m = j + 1; m < n; m++) begin
        exp_a[m] = 1'b1;
        if ((m - j) % 8 == 0) begin
          if (win(m) != COM_SYM) begin
            exp_v[m] = 1'b1;
            cap[m]   = win(m);
          end
        end
`ifdef SP_RX_LOSS_DETECT_EN
        else if (win(m) == COM_SYM) begin
          exp_a[m] = 1'b0;
          lost     = 1'b1;
          break;
        end
`endif
      end
      i = lost ? m + 1 : n;
    end
    d = 8'h00;
    for (int x = 0; x < n; x++) begin
      if (exp_v[x]) d = cap[x];
      exp_d.push_back(d);
    end
  endtask

  task automatic run_episode(input string nm, input int rst_cycles);
    model_run();
    reset = 1'b1;
    repeat (rst_cycles) begin
      bus.data_in = 1'($urandom);
      @(posedge clk_32f); #1;
    end
    reset = 1'b0;
    obs_v = {}; obs_d = {}; obs_a = {};
    for (int x = 0; x < stim.size(); x++) begin
      bus.data_in = stim[x];
      @(posedge clk_32f); #1;
      obs_v.push_back(bus.valid_out);
      obs_d.push_back(bus.data_out);
      obs_a.push_back(bus.active);
      check($sformatf("%s valid@%0d", nm, x), 32'(bus.valid_out), 32'(exp_v[x]));
      check($sformatf("%s data@%0d", nm, x), 32'(bus.data_out), 32'(exp_d[x]));
      check($sformatf("%s active@%0d", nm, x), 32'(bus.active), 32'(exp_a[x]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, rise;
    logic [7:0] first;
    int r;

    vt[0] = '{nlead:0, nbytes:6, bytes:{8'hBC,8'hBC,8'hBC,8'hBC,8'h55,8'hA3,16'h0},
              exp_cnt:2, exp_first:8'h55, exp_last:8'hA3, exp_act:1'b1, exp_rise:31};
    vt[1] = '{nlead:3, nbytes:5, bytes:{8'hBC,8'hBC,8'hBC,8'hBC,8'h7E,24'h0},
              exp_cnt:1, exp_first:8'h7E, exp_last:8'h7E, exp_act:1'b1, exp_rise:34};
    vt[2] = '{nlead:0, nbytes:8, bytes:{8'hBC,8'hBC,8'h12,8'hBC,8'hBC,8'hBC,8'hBC,8'h34},
              exp_cnt:1, exp_first:8'h34, exp_last:8'h34, exp_act:1'b1, exp_rise:55};
    vt[3] = '{nlead:0, nbytes:8, bytes:{8'hBC,8'hBC,8'hBC,8'hBC,8'h01,8'hBC,8'hBC,8'h02},
              exp_cnt:2, exp_first:8'h01, exp_last:8'h02, exp_act:1'b1, exp_rise:31};
    vt[4] = '{nlead:0, nbytes:4, bytes:{8'hBC,8'hBC,8'hBC,8'h55,32'h0},
              exp_cnt:0, exp_first:8'h00, exp_last:8'h00, exp_act:1'b0, exp_rise:-1};

    // Reset held 3 cycles with random serial input
    reset = 1'b1;
    repeat (3) begin
      bus.data_in = 1'($urandom);
      @(posedge clk_32f); #1;
    end
    check("reset data_out", 32'(bus.data_out), 32'h00);
    check("reset valid_out", 32'(bus.valid_out), 32'h0);
    check("reset active", 32'(bus.active), 32'h0);

    // Directed vectors
    for (int t = 0; t < 5; t++) begin
      stim = {};
      repeat (vt[t].nlead) stim.push_back(1'($urandom));
      for (int b = 0; b < vt[t].nbytes; b++) push_byte(vt[t].bytes[63 - 8*b -: 8]);
      run_episode($sformatf("vec%0d", t), 2);
      cnt = 0; rise = -1; first = 8'h00;
      for (int x = 0; x < obs_v.size(); x++) begin
        if (obs_v[x] === 1'b1) begin
          if (cnt == 0) first = obs_d[x];
          cnt++;
        end
        if (rise < 0 && obs_a[x] === 1'b1) rise = x;
      end
      check($sformatf("vec%0d strobes", t), 32'(cnt), 32'(vt[t].exp_cnt));
      check($sformatf("vec%0d first", t), 32'(first), 32'(vt[t].exp_first));
      check($sformatf("vec%0d last", t), 32'(obs_d[obs_d.size()-1]), 32'(vt[t].exp_last));
      check($sformatf("vec%0d active", t), 32'(obs_a[obs_a.size()-1]), 32'(vt[t].exp_act));
      check($sformatf("vec%0d rise", t), 32'(rise), 32'(vt[t].exp_rise));
    end

    // Slip by one bit while ACTIVE, then reset mid-byte
    stim = {};
    repeat (4) push_byte(COM_SYM);
    push_byte(8'h11);
    stim.push_back(1'b0);
    push_byte(COM_SYM);
    stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
    run_episode("loss", 1);
`ifdef SP_RX_LOSS_DETECT_EN
    check("loss active after slipped COM", 32'(obs_a[48]), 32'h0);
`else
    check("loss active after slipped COM", 32'(obs_a[48]), 32'h1);
`endif
    check("loss strobe on slipped byte", 32'(obs_v[47]), 32'h1);
    check("loss data on slipped byte", 32'(obs_d[47]), 32'h5E);
    reset = 1'b1;
    bus.data_in = 1'($urandom);
    @(posedge clk_32f); #1;
    check("midreset data_out", 32'(bus.data_out), 32'h00);
    check("midreset valid_out", 32'(bus.valid_out), 32'h0);
    check("midreset active", 32'(bus.active), 32'h0);
    reset = 1'b0;

    // Randomized episodes against the model
    for (int e = 0; e < 6; e++) begin
      stim = {};
      repeat ($urandom_range(0, 7)) stim.push_back(1'($urandom));
      repeat ($urandom_range(COM_COUNT - 1, COM_COUNT + 2)) push_byte(COM_SYM);
      for (int it = 0; it < 40; it++) begin
        r = int'($urandom_range(0, 11));
        if (r < 2) push_byte(COM_SYM);
        else if (r == 2) stim.push_back(1'($urandom));
        else if (r == 3) repeat ($urandom_range(1, 7)) stim.push_back(1'($urandom));
        else if (r == 4) repeat (COM_COUNT) push_byte(COM_SYM);
        else push_byte(8'($urandom));
      end
      run_episode($sformatf("rand%0d", e), int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_rx.md
# serial_paralelo_rx

Receive-side serial-to-parallel deserializer for the PCIe PHY lane, the direct consumer of the transmit serializer's bit stream. It samples one bit per `clk_32f` cycle, MSB first, and finds byte alignment by hunting for the COM symbol `8'hBC`. Once a run of consecutive COMs is seen it declares the lane active and presents every non-COM byte as a parallel word with a one-cycle valid strobe. Idle COMs are absorbed, so the downstream parallel logic sees only payload.

## Interface
- `COM_COUNT`, default 4: number of consecutive aligned COM bytes needed to enter ACTIVE; legal range 1–15.
- `clk_32f`  in  1: bit clock, one serial bit per rising edge; the only clock.
- `reset`  in  1: synchronous, active-high.
- `data_in`  in  1: serial bit, MSB of each byte first.
- `data_out`  out  8: last received payload byte; held between strobes.
- `valid_out`  out  1: one-cycle strobe marking a new payload byte on `data_out`.
- `active`  out  1: high while the lane is aligned and in ACTIVE.

## Operation
- Shift register: `sr` (8 bits). Combinational `nsr = {sr[6:0], data_in}`; `sr <= nsr` every cycle outside reset.
- Phase counter: `cnt` (3 bits), increments modulo 8 every cycle. A byte boundary is a cycle with `cnt == 7`; that cycle's `nsr` is a complete byte.
- COM counter: `com_cnt` (4 bits).
- States:
  - SEARCH: compares `nsr` every cycle. On `nsr == 8'hBC`: `cnt <= 0`, `com_cnt <= 1`. If `COM_COUNT == 1`, go to ACTIVE; otherwise go to ALIGN.
  - ALIGN: acts at boundaries only.
    - `nsr == 8'hBC`: `com_cnt` increments; when the new value equals `COM_COUNT`, go to ACTIVE.
    - Any other byte: go to SEARCH, `com_cnt <= 0`, no output.
    - No `valid_out` is ever produced in ALIGN.
  - ACTIVE: at each boundary:
    - `nsr != 8'hBC`: `data_out <= nsr`, `valid_out <= 1`.
    - `nsr == 8'hBC`: `valid_out <= 0`, `data_out` unchanged.
    - `active = 1` throughout ACTIVE.
- `valid_out` is 0 in every non-boundary cycle.
- Without the loss-detect feature, ACTIVE exits only on `reset`.
- A byte equal to `8'hBC` is never delivered as payload.

## Timing
- Reset values: `data_out = 8'h00`, `valid_out = 0`, `active = 0`, `sr = 0`, `cnt = 0`, `com_cnt = 0`, state SEARCH.
- Latency: the edge that samples a byte's LSB also registers `data_out`/`valid_out`. The strobe is visible in the following cycle, 0 extra cycles beyond the byte.
- Strobe spacing: at most one strobe per 8 cycles.
- `active` rises in the cycle after the boundary that completes the `COM_COUNT`-th COM. The first payload strobe follows 8 cycles later at the earliest.
- Reset asserted mid-byte or in any state: all registers take reset values on that edge. The partial byte is discarded.
- In SEARCH, a match may occur at any bit offset. The first match wins, with no preference among overlapping offsets.

## Configuration
- Macro `SP_RX_LOSS_DETECT_EN`.
- Defined: in ACTIVE, `nsr == 8'hBC` in a non-boundary cycle (`cnt != 7`) is a misaligned COM.
  - Next edge: state SEARCH, `active <= 0`, `com_cnt <= 0`, `valid_out <= 0`.
  - `data_out` holds.
  - A boundary in the same cycle is impossible by definition.
- Undefined: misaligned COMs in ACTIVE are ignored. Only `reset` leaves ACTIVE.

## Structure
- Package `sp_rx_pkg`:
  - `COM_SYM = 8'hBC`;
  - state enum `SEARCH`/`ALIGN`/`ACTIVE`;
  - phase-width constant (3).
- One sub-module, `sp_rx_comma_det`: takes `nsr`, outputs `is_com`.
  - Purely combinational.
  - Reused by the serializer's test bench checker.
- The top holds the shift register, counters and FSM.

## Test plan
- Reset check: hold `reset` 3 cycles with random `data_in` → `data_out = 00`, `valid_out = 0`, `active = 0`.
- Basic lock: 4×`BC` then `0x55`, `0xA3`, MSB first, aligned → `active` high after the 4th `BC`; strobes at 8-cycle spacing with `55` then `A3`.
- Arbitrary bit offset: 3 random bits, then 4×`BC`, then `0x7E` → lock at offset 3; single strobe `data_out = 7E`.
- Broken alignment: `BC`, `BC`, `0x12`, then 4×`BC`, then `0x34` → no strobe for `12`; `active` only after the final 4 `BC`; strobe `34`.
- Idle absorption: in ACTIVE, `0x01`, `BC`, `BC`, `0x02` → exactly 2 strobes (`01`, `02`), `active` stays 1.
- Loss and reset: in ACTIVE, insert one extra bit before a `BC`.
  - With `SP_RX_LOSS_DETECT_EN`: `active` falls within 8 cycles.
  - Without the macro: `active` stays 1.
  - Then assert `reset` mid-byte: all outputs return to reset values next cycle.
